// File: rtl/shift_req_stage.sv
// shift_req_stage: request FIFO plus issue/capture stage feeding the external
// 4-bit barrel rotator. Right rotates are issued as the equivalent left select.
module shift_req_stage #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_data,
  input  logic [1:0]               in_amt,
  input  logic                     in_dir,
  output logic [3:0]               sh_data_o,
  output logic [1:0]               sh_sel_o,
  input  logic [3:0]               sh_result_i,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               out_data,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [CNT_W-1:0]         ops_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // Right rotate by n equals left rotate by (4 - n) mod 4, i.e. -n mod 4.
  function automatic logic [1:0] left_sel(input logic [1:0] amt, input logic dir);
    return dir ? (2'd0 - amt) : amt;
  endfunction

  logic [6:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic          push;
  logic          load;
  logic [6:0]    head_p0;
  logic [3:0]    res_p1;
  logic          vld_p1;

  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign load     = !empty && (!vld_p1 || out_ready);

  // ---- stage p0: FIFO head presented to the rotator ----
  assign head_p0   = mem[rptr];
  assign sh_data_o = empty ? 4'd0 : head_p0[6:3];
  assign sh_sel_o  = empty ? 2'd0 : left_sel(head_p0[2:1], head_p0[0]);

  // Request storage; payload only, never reset.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {in_data, in_amt, in_dir};
  end

  // Read/write pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (load) rptr <= rptr + 1'b1;
      case ({push, load})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---- stage p1: registered rotator result ----
  // Capture the rotator output on issue; drop valid once taken with nothing new.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      res_p1 <= 4'd0;
    end else if (load) begin
      vld_p1 <= 1'b1;
      res_p1 <= sh_result_i;
    end else if (vld_p1 && out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  // Count results accepted downstream, wrapping naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ops_cnt <= '0;
    else if (vld_p1 && out_ready) ops_cnt <= ops_cnt + 1'b1;
  end

  assign out_valid  = vld_p1;
  assign out_data   = res_p1;
  assign fifo_count = count;

endmodule
